// File: rtl/in_service_ctrl.sv
// In-service tracking for the interrupt controller: ISR, rotating priority
// pointer, two-pulse acknowledge sequence and all EOI flavours.
module in_service_ctrl #(
  parameter  int NUM_IRQ = 8,
  localparam int LW      = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ack_first,
  input  logic               ack_second,
  input  logic [NUM_IRQ-1:0] grant,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic               eoi_rotate,
  input  logic [LW-1:0]      eoi_level,
  input  logic               set_priority_valid,
  input  logic [LW-1:0]      set_priority_level,
  input  logic               auto_eoi,
  input  logic               auto_rotate,
  input  logic               special_mask_mode,
  input  logic [NUM_IRQ-1:0] interrupt_mask,
  output logic [NUM_IRQ-1:0] in_service_register,
  output logic [NUM_IRQ-1:0] highest_level_in_service,
  output logic [LW-1:0]      priority_rotate,
  output logic               ack_pending,
  output logic               ack_error
);

  localparam logic [NUM_IRQ-1:0] ONE = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WAIT2 = 1'b1
  } state_t;

  // First set bit of v scanning from lowest+1 downwards in priority, wrapping.
  // Passing lowest = all-ones yields the lowest-index set bit.
  function automatic logic [LW-1:0] first_index(input logic [NUM_IRQ-1:0] v,
                                                input logic [LW-1:0] lowest);
    logic [LW-1:0] idx;
    logic          found;
    first_index = '0;
    found       = 1'b0;
    for (int i = 1; i <= NUM_IRQ; i++) begin
      idx = lowest + LW'(i);
      if (!found && v[idx]) begin
        found       = 1'b1;
        first_index = idx;
      end else begin
        found = found;
      end
    end
  endfunction

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] hlis_q, hlis_d;
  logic [LW-1:0]      prio_q, prio_d;
  logic [LW-1:0]      ack_level_q, ack_level_d;
  logic               spurious_q, spurious_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;

  logic [NUM_IRQ-1:0] latch_set_s, aeoi_clear_s, eoi_clear_s;
  logic [NUM_IRQ-1:0] elig_s, elig_next_s;
  logic [LW-1:0]      grant_level_s, ns_level_s, eoi_rot_level_s;
  logic               aeoi_rot_s, eoi_rot_s;

  // Acknowledge sequence FSM: latching on the first pulse, AEOI on the second.
  always_comb begin
    state_d       = state_q;
    ack_level_d   = ack_level_q;
    spurious_d    = spurious_q;
    err_d         = 1'b0;
    latch_set_s   = '0;
    aeoi_clear_s  = '0;
    aeoi_rot_s    = 1'b0;
    grant_level_s = first_index(grant, {LW{1'b1}});
    case (state_q)
      S_IDLE: begin
        if (ack_first) begin
          state_d     = S_WAIT2;
          ack_level_d = grant_level_s;
          spurious_d  = ~|grant;
          latch_set_s = (|grant) ? (ONE << grant_level_s) : '0;
        end else begin
          state_d = S_IDLE;
        end
        err_d = ack_second;
      end
      S_WAIT2: begin
        if (ack_second) begin
          state_d = S_IDLE;
          if (auto_eoi && !spurious_q) begin
            aeoi_clear_s = ONE << ack_level_q;
            aeoi_rot_s   = auto_rotate;
          end else begin
            aeoi_rot_s = 1'b0;
          end
        end else begin
          state_d = S_WAIT2;
        end
        err_d = ack_first;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // EOI decode, pointer precedence and next-state ISR / highest-level outputs.
  always_comb begin
    elig_s          = isr_q & ~(interrupt_mask & {NUM_IRQ{special_mask_mode}});
    ns_level_s      = first_index(elig_s, prio_q);
    eoi_clear_s     = '0;
    eoi_rot_s       = 1'b0;
    eoi_rot_level_s = ns_level_s;
    if (eoi_valid) begin
      if (eoi_specific) begin
        eoi_clear_s     = ONE << eoi_level;
        eoi_rot_s       = eoi_rotate;
        eoi_rot_level_s = eoi_level;
      end else if (|elig_s) begin
        eoi_clear_s = ONE << ns_level_s;
        eoi_rot_s   = eoi_rotate;
      end else begin
        eoi_rot_s = 1'b0;
      end
    end else begin
      eoi_rot_s = 1'b0;
    end

    if (set_priority_valid) begin
      prio_d = set_priority_level;
    end else if (eoi_rot_s) begin
      prio_d = eoi_rot_level_s;
    end else if (aeoi_rot_s) begin
      prio_d = ack_level_q;
    end else begin
      prio_d = prio_q;
    end

    // Set is OR-ed last so a same-cycle latch beats any clear of that bit.
    isr_d       = (isr_q & ~eoi_clear_s & ~aeoi_clear_s) | latch_set_s;
    elig_next_s = isr_d & ~(interrupt_mask & {NUM_IRQ{special_mask_mode}});
    if (|elig_next_s) begin
      hlis_d = ONE << first_index(elig_next_s, prio_d);
    end else begin
      hlis_d = '0;
    end
    pending_d = (state_d == S_WAIT2);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      isr_q       <= '0;
      hlis_q      <= '0;
      prio_q      <= {LW{1'b1}};
      ack_level_q <= '0;
      spurious_q  <= 1'b0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      hlis_q      <= hlis_d;
      prio_q      <= prio_d;
      ack_level_q <= ack_level_d;
      spurious_q  <= spurious_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = hlis_q;
  assign priority_rotate          = prio_q;
  assign ack_pending              = pending_q;
  assign ack_error                = err_q;

endmodule

// File: doc/in_service_ctrl.md
# in_service_ctrl

Parametrised in-service tracking block for the interrupt controller. It holds the in-service register (ISR) for `NUM_IRQ` levels and tracks the rotating priority pointer. It runs the two-pulse acknowledge sequence and handles non-specific, specific, rotating and automatic EOI internally. It sits between the priority resolver, which supplies the one-hot grant, and the control-word logic, which supplies EOI and mode commands. It feeds the resolver its highest in-service level for priority masking.

## Interface
- `NUM_IRQ`, 8: number of interrupt levels; power of two, 2..32.
- `LW`, `$clog2(NUM_IRQ)`: level index width (derived, not overridden).

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ack_first` in 1: first acknowledge pulse (one cycle); latches `grant`.
- `ack_second` in 1: second acknowledge pulse (one cycle); completes the sequence.
- `grant` in NUM_IRQ: one-hot winning request from the resolver; all-zero means spurious.
- `eoi_valid` in 1: EOI command strobe.
- `eoi_specific` in 1: 1 = clear `eoi_level`; 0 = clear the highest in service.
- `eoi_rotate` in 1: rotate priority on this EOI.
- `eoi_level` in LW: target level for a specific EOI.
- `set_priority_valid` in 1: load the priority pointer.
- `set_priority_level` in LW: new lowest-priority level.
- `auto_eoi` in 1: AEOI mode.
- `auto_rotate` in 1: rotate on AEOI.
- `special_mask_mode` in 1: SMM enable.
- `interrupt_mask` in NUM_IRQ: IMR; used only when SMM is on.
- `in_service_register` out NUM_IRQ: ISR, registered.
- `highest_level_in_service` out NUM_IRQ: one-hot highest-priority ISR bit, registered; zero if none.
- `priority_rotate` out LW: current lowest-priority level, registered.
- `ack_pending` out 1: high between `ack_first` and `ack_second`.
- `ack_error` out 1: one-cycle pulse on a sequence violation.

## Operation
- **Priority order:** highest priority is `(priority_rotate+1) mod NUM_IRQ`, descending cyclically to `priority_rotate`.
- **Eligible ISR bits:** ISR & ~(special_mask_mode ? interrupt_mask : 0).
- **highest_level_in_service:** highest-priority eligible bit of the next ISR value.
- **FSM IDLE:**
  - `ack_first` → ISR |= grant; capture `ack_level` = index of grant (or a spurious flag if grant==0); go to WAIT2.
  - `ack_second` in IDLE → `ack_error`; no state change.
- **FSM WAIT2:**
  - `ack_second` → if `auto_eoi` and not spurious: clear ISR[ack_level]; if also `auto_rotate`: priority_rotate <= ack_level. Go to IDLE.
  - `ack_first` in WAIT2 → `ack_error`; ignored; stay in WAIT2.
- **Non-specific EOI:**
  - Clears the highest eligible ISR bit.
  - With `eoi_rotate`, priority_rotate <= that level.
  - If no eligible bit: no-op, no rotation.
- **Specific EOI:**
  - Clears ISR[eoi_level] unconditionally (mask ignored).
  - With `eoi_rotate`, priority_rotate <= eoi_level even if the bit was already clear.
- **set_priority_valid:** priority_rotate <= set_priority_level.
- **Next ISR:** next ISR = (ISR & ~eoi_clear & ~aeoi_clear) | latch_set.
- **Same-cycle set and clear:** a set of a bit wins over a clear of the same bit.
- **Same-cycle pointer updates, precedence:** `set_priority_valid` > EOI rotate > AEOI rotate.
- **Non-one-hot grant:** only the lowest-index set bit is latched.

## Timing
- **Reset values:**
  - ISR = 0, highest_level_in_service = 0.
  - priority_rotate = NUM_IRQ-1, so level 0 is highest.
  - FSM IDLE, ack_pending = 0, ack_error = 0.
- **Latency:** all commands take effect at the next rising edge, and all outputs update on that same edge (1-cycle latency). Outputs are glitch-free registers.
- **ack_pending:** rises the cycle after `ack_first`; falls the cycle after `ack_second`.
- **ack_error:** high for exactly one cycle after the offending pulse.
- **Reset mid-sequence:** reset asserted in WAIT2 aborts the sequence immediately. No AEOI occurs, and all state takes its reset values.
- **Back-to-back:** `ack_second` and the next `ack_first` may arrive on consecutive cycles; there are no dead cycles.
- **Pointer wrap-around:** priority_rotate wraps modulo NUM_IRQ.

## Test plan
1. **Reset and basic EOI (NUM_IRQ=8):** release reset, ack_first with grant=0x04, then ack_second, auto_eoi=0 → ISR=0x04, highest=0x04, priority_rotate=7. Then non-specific EOI → ISR=0x00, highest=0x00.
2. **Nested interrupts, rotating EOI:** ISR=0x90 (levels 4 and 7), then non-specific EOI with rotate → ISR=0x80, priority_rotate=4, highest=0x80.
3. **AEOI with rotation:** auto_eoi=1, auto_rotate=1, grant=0x02 → ISR=0x02 after ack_first, ISR=0x00 and priority_rotate=1 after ack_second.
4. **Special mask mode:** ISR=0x06, SMM=1, mask=0x02 → highest=0x04. Non-specific EOI → ISR=0x02.
5. **Collisions:**
   - Same-cycle specific EOI level 3 and ack_first grant=0x08 → ISR bit 3 set.
   - Same-cycle set_priority=5 and rotating EOI → priority_rotate=5.
6. **Sequence errors and reset:**
   - ack_second in IDLE → ack_error pulses one cycle.
   - ack_first in WAIT2 → ack_error, ISR unchanged.
   - Async reset in WAIT2 with AEOI on → all outputs zero and priority_rotate=7 immediately, with no clock edge needed.
   - NUM_IRQ=16 rerun of scenario 2 with levels 9 and 15 → priority_rotate=9.
